// File: rtl/snn_noc_pkg.sv
// Shared definitions for the inter-core spike network: packet layout, the
// empty-connection marker and the receive-side FSM states.
package snn_noc_pkg;

  localparam int ADDR_W = 12;
  localparam int PKT_W  = 2 * ADDR_W;

  // Field indices within a packet; a field occupies [idx*ADDR_W +: ADDR_W].
  localparam int PKT_DEST   = 0;
  localparam int PKT_ORIGIN = 1;

  localparam logic [ADDR_W-1:0] EMPTY_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    HOLD
  } rx_state_e;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous packet FIFO with occupancy count; a push while full is refused
// even if a pop happens in the same cycle.
module spike_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spike_packet_receiver.sv
// Router ejection side: buffers {origin, destination} packets and strobes the
// addressed local neuron's MAC with the origin. Optional counters: SPIKE_RX_STATS_EN.
module spike_packet_receiver #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = snn_noc_pkg::ADDR_W,
  parameter int FIFO_DEPTH  = 8,
  parameter int BASE_ADDR   = 0
) (
  input  logic                            CLK,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic [2*ADDR_W-1:0]             pkt_in,
  input  logic                            pkt_valid,
  output logic                            pkt_ready,
  output logic [NUM_NEURONS*ADDR_W-1:0]   source_address_out,
  output logic [NUM_NEURONS-1:0]          source_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
`ifdef SPIKE_RX_STATS_EN
  ,
  output logic [15:0]                     rx_count,
  output logic [15:0]                     drop_count
`endif
);
  import snn_noc_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] EMPTY = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_NEURONS);

  rx_state_e           state_q;
  rx_state_e           state_d;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*ADDR_W-1:0] head_pkt;
  logic [ADDR_W-1:0]   head_origin;
  logic [ADDR_W-1:0]   head_dest;
  logic [ADDR_W-1:0]   idx;
  logic                in_range;
  logic                dispatch;

  assign pkt_ready = !fifo_full;
  assign push      = pkt_valid && pkt_ready;

  spike_fifo #(
    .WIDTH (2*ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (pkt_in),
    .dout  (head_pkt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Wrap-around subtraction makes destinations below BASE_ADDR fall out of range.
  assign head_origin = head_pkt[PKT_ORIGIN*ADDR_W +: ADDR_W];
  assign head_dest   = head_pkt[PKT_DEST*ADDR_W +: ADDR_W];
  assign idx         = head_dest - BASE;
  assign in_range    = (idx < LIMIT);
  assign dispatch    = pop && in_range;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (push || !fifo_empty) state_d = DISPATCH;
      end
      DISPATCH: begin
        if (clear) begin
          state_d = HOLD;
        end else if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          pop = 1'b1;
          if (fifo_level == LVL_W'(1) && !push) state_d = IDLE;
        end
      end
      HOLD: begin
        if (!clear) state_d = (fifo_empty && !push) ? IDLE : DISPATCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // A dispatched slot reverts to EMPTY one cycle later so repeated origins toggle.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      source_address_out <= {NUM_NEURONS{EMPTY}};
      source_valid       <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (dispatch && idx == ADDR_W'(i))
          source_address_out[i*ADDR_W +: ADDR_W] <= head_origin;
        else if (source_valid[i])
          source_address_out[i*ADDR_W +: ADDR_W] <= EMPTY;
        source_valid[i] <= dispatch && (idx == ADDR_W'(i));
      end
    end
  end

`ifdef SPIKE_RX_STATS_EN
  logic clear_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      clear_q    <= 1'b0;
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      clear_q <= clear;
      if (clear && !clear_q) begin
        rx_count   <= '0;
        drop_count <= '0;
      end else begin
        if (push)              rx_count   <= rx_count + 16'd1;
        if (pop && !in_range)  drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spike_packet_receiver.sv
// Directed bench for spike_packet_receiver: reset, latency, full FIFO,
// out-of-range drop, clear mid-stream and asynchronous reset mid-dispatch.
module tb_spike_packet_receiver;

  logic         CLK = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         pkt_valid = 1'b0;
  logic [23:0]  pkt_in = '0;
  logic         pkt_ready;
  logic [119:0] source_address_out;
  logic [9:0]   source_valid;
  logic [3:0]   fifo_level;
`ifdef SPIKE_RX_STATS_EN
  logic [15:0]  rx_count;
  logic [15:0]  drop_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  spike_packet_receiver #(
    .NUM_NEURONS (10),
    .ADDR_W      (12),
    .FIFO_DEPTH  (8),
    .BASE_ADDR   (0)
  ) dut (
    .CLK                (CLK),
    .reset_n            (reset_n),
    .clear              (clear),
    .pkt_in             (pkt_in),
    .pkt_valid          (pkt_valid),
    .pkt_ready          (pkt_ready),
    .source_address_out (source_address_out),
    .source_valid       (source_valid),
    .fifo_level         (fifo_level)
`ifdef SPIKE_RX_STATS_EN
    ,
    .rx_count           (rx_count),
    .drop_count         (drop_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] slot(input int i);
    return source_address_out[i*12 +: 12];
  endfunction

  task automatic push_pkt(input logic [11:0] origin, input logic [11:0] dest);
    pkt_in    = {origin, dest};
    pkt_valid = 1'b1;
    @(negedge CLK);
    pkt_valid = 1'b0;
  endtask

  // Advance to the first negedge showing a strobe, bounded.
  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    while (source_valid == '0 && n < 6) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_seen"}, 32'(source_valid != '0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 10; i++) check($sformatf("rst_slot%0d", i), 32'(slot(i)), 32'hFFF);
    check("rst_valid", 32'(source_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    reset_n = 1'b1;
    @(negedge CLK);
    check("rst_ready", 32'(pkt_ready), 32'd1);

    // Single dispatch: strobe exactly one cycle after the push edge
    push_pkt(12'd0, 12'd3);
    check("single_wait_valid", 32'(source_valid), 32'd0);
    check("single_wait_level", 32'(fifo_level), 32'd1);
    @(negedge CLK);
    check("single_valid", 32'(source_valid), 32'h008);
    check("single_slot3", 32'(slot(3)), 32'h000);
    @(negedge CLK);
    check("single_after_valid", 32'(source_valid), 32'd0);
    check("single_after_slot3", 32'(slot(3)), 32'hFFF);
    check("single_after_level", 32'(fifo_level), 32'd0);

    // Fill under clear: 9 offered, 8 accepted
    clear = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 9; k++) begin
      pkt_in    = {12'(32'h100 + k), 12'(k)};
      pkt_valid = 1'b1;
      @(negedge CLK);
    end
    pkt_valid = 1'b0;
    check("full_level", 32'(fifo_level), 32'd8);
    check("full_ready", 32'(pkt_ready), 32'd0);
    check("full_no_strobe", 32'(source_valid), 32'd0);
`ifdef SPIKE_RX_STATS_EN
    check("full_rx_count", 32'(rx_count), 32'd8);
`endif
    clear = 1'b0;
    wait_strobe("burst_first");
    for (int k = 0; k < 8; k++) begin
      check($sformatf("burst_valid%0d", k), 32'(source_valid), 32'(1 << k));
      check($sformatf("burst_slot%0d", k), 32'(slot(k)), 32'h100 + k);
      if (k > 0) check($sformatf("burst_prev%0d", k), 32'(slot(k - 1)), 32'hFFF);
      @(negedge CLK);
    end
    check("burst_end_valid", 32'(source_valid), 32'd0);
    check("burst_end_level", 32'(fifo_level), 32'd0);
    check("burst_end_slot7", 32'(slot(7)), 32'hFFF);

    // Out-of-range destination is consumed silently
    push_pkt(12'h0AB, 12'd10);
    repeat (3) begin
      check("oor_no_strobe", 32'(source_valid), 32'd0);
      @(negedge CLK);
    end
    check("oor_level", 32'(fifo_level), 32'd0);
    check("oor_slot0", 32'(slot(0)), 32'hFFF);
    check("oor_slot9", 32'(slot(9)), 32'hFFF);
`ifdef SPIKE_RX_STATS_EN
    check("oor_drop_count", 32'(drop_count), 32'd1);
    check("oor_rx_count", 32'(rx_count), 32'd9);
`endif

    // Clear pulse after two strobes; remaining packets still delivered in order
    clear = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) push_pkt(12'(32'h200 + k), 12'(2 * k + 1));
    clear = 1'b0;
    wait_strobe("clr_first");
    check("clr_valid0", 32'(source_valid), 32'h002);
    check("clr_slot1", 32'(slot(1)), 32'h200);
    @(negedge CLK);
    check("clr_valid1", 32'(source_valid), 32'h008);
    check("clr_slot3", 32'(slot(3)), 32'h201);
    clear = 1'b1;
    @(negedge CLK);
    check("clr_hold_valid", 32'(source_valid), 32'd0);
    check("clr_hold_level", 32'(fifo_level), 32'd2);
    clear = 1'b0;
    wait_strobe("clr_resume");
    check("clr_valid2", 32'(source_valid), 32'h020);
    check("clr_slot5", 32'(slot(5)), 32'h202);
    @(negedge CLK);
    check("clr_valid3", 32'(source_valid), 32'h080);
    check("clr_slot7", 32'(slot(7)), 32'h203);
    @(negedge CLK);
    check("clr_end_valid", 32'(source_valid), 32'd0);
    check("clr_end_level", 32'(fifo_level), 32'd0);

    // Asynchronous reset between edges while dispatching
    clear = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 5; k++) push_pkt(12'(32'h300 + k), 12'(k));
    clear = 1'b0;
    wait_strobe("arst_first");
    check("arst_pre_valid", 32'(source_valid), 32'h001);
    check("arst_pre_slot0", 32'(slot(0)), 32'h300);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(source_valid), 32'd0);
    check("arst_slot0", 32'(slot(0)), 32'hFFF);
    check("arst_level", 32'(fifo_level), 32'd0);
    @(negedge CLK);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("arst_no_strobe", 32'(source_valid), 32'd0);
    end
    check("arst_end_level", 32'(fifo_level), 32'd0);
    check("arst_end_ready", 32'(pkt_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
